// File: rtl/sat_vec_accum.sv
// Multi-lane saturating vector accumulator.
// Sums a stream of signed beats (one value per lane) into per-lane accumulators until the
// last beat of a vector, then holds the saturated totals, sticky overflow flags and beat
// count on a valid/ready output until they are consumed.
// Optional feature macro: SAT_VEC_ACCUM_GUARD_EN widens the accumulators by GUARD bits and
// clamps to WIDTH only at the output, so transient overflow that returns into range is not
// flagged.
module sat_vec_accum #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LANES     = 4,
    parameter int unsigned MAX_BEATS = 256,
    parameter int unsigned GUARD     = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_in_valid,
    output logic                           o_in_ready,
    input  logic [LANES*WIDTH-1:0]         i_in_data,
    input  logic                           i_in_last,
    output logic                           o_out_valid,
    input  logic                           i_out_ready,
    output logic [LANES*WIDTH-1:0]         o_out_data,
    output logic [LANES-1:0]               o_out_ovf,
    output logic [$clog2(MAX_BEATS+1)-1:0] o_out_beats
);

    localparam int unsigned CW = $clog2(MAX_BEATS + 1);

`ifdef SAT_VEC_ACCUM_GUARD_EN
    localparam bit GuardEn = 1'b1;
`else
    localparam bit GuardEn = 1'b0;
`endif

    // Accumulator width: guard bits only take part when the feature is enabled.
    localparam int unsigned AW = WIDTH + (GuardEn ? GUARD : 0);

    localparam logic [AW-1:0] AccMax = {1'b0, {(AW - 1){1'b1}}};
    localparam logic [AW-1:0] AccMin = {1'b1, {(AW - 1){1'b0}}};
`ifdef SAT_VEC_ACCUM_GUARD_EN
    localparam logic [WIDTH-1:0] OutMax = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] OutMin = {1'b1, {(WIDTH - 1){1'b0}}};
`endif

    typedef enum logic {
        StAccum,
        StDone
    } state_e;

    state_e                         r_state;
    logic                           r_in_ready;
    logic                           r_out_valid;
    logic [LANES-1:0][AW-1:0]       r_acc;
    logic [LANES-1:0]               r_ovf;
    logic [CW-1:0]                  r_cnt;
    logic [LANES-1:0][WIDTH-1:0]    r_out_data;
    logic [LANES-1:0]               r_out_ovf;

    logic [LANES-1:0][AW:0]         w_ext;
    logic [LANES-1:0][AW:0]         w_sum;
    logic [LANES-1:0][AW-1:0]       w_acc_next;
    logic [LANES-1:0]               w_ovf_next;
    logic [LANES-1:0][WIDTH-1:0]    w_out_data;
    logic [LANES-1:0]               w_out_ovf;
    logic [CW-1:0]                  w_cnt_next;
    logic                           w_accept;
    logic                           w_last;

    assign w_accept   = i_in_valid & r_in_ready;
    assign w_cnt_next = r_cnt + CW'(1);
    // Beat number MAX_BEATS closes the vector even without in_last.
    assign w_last     = i_in_last | (w_cnt_next == CW'(MAX_BEATS));

    // Per-lane saturating add of the incoming beat, plus the output-width view of the result.
    always_comb begin
        w_ext      = '0;
        w_sum      = '0;
        w_acc_next = '0;
        w_ovf_next = '0;
        w_out_data = '0;
        w_out_ovf  = '0;
        for (int i = 0; i < LANES; i++) begin
            w_ext[i] = {{(AW + 1 - WIDTH){i_in_data[i*WIDTH + WIDTH - 1]}},
                        i_in_data[i*WIDTH +: WIDTH]};
            w_sum[i] = {r_acc[i][AW-1], r_acc[i]} + w_ext[i];
            // The two top bits of the one-bit-wider sum disagree exactly on overflow.
            if (w_sum[i][AW] != w_sum[i][AW-1]) begin
                w_acc_next[i] = w_sum[i][AW] ? AccMin : AccMax;
                w_ovf_next[i] = 1'b1;
            end else begin
                w_acc_next[i] = w_sum[i][AW-1:0];
                w_ovf_next[i] = r_ovf[i];
            end
`ifdef SAT_VEC_ACCUM_GUARD_EN
            // In range when every bit from the output sign bit upward agrees.
            if ((&w_acc_next[i][AW-1:WIDTH-1]) || !(|w_acc_next[i][AW-1:WIDTH-1])) begin
                w_out_data[i] = w_acc_next[i][WIDTH-1:0];
                w_out_ovf[i]  = w_ovf_next[i];
            end else begin
                w_out_data[i] = w_acc_next[i][AW-1] ? OutMin : OutMax;
                w_out_ovf[i]  = 1'b1;
            end
`else
            w_out_data[i] = w_acc_next[i];
            w_out_ovf[i]  = w_ovf_next[i];
`endif
        end
    end

    // Two-state control FSM with registered handshake outputs and result capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StAccum;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_ovf   <= '0;
        end else begin
            unique case (r_state)
                StAccum: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_ovf <= w_ovf_next;
                        r_cnt <= w_cnt_next;
                        if (w_last) begin
                            r_state     <= StDone;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_out_data;
                            r_out_ovf   <= w_out_ovf;
                        end
                    end
                end
                StDone: begin
                    // Consuming the result starts a fresh vector from zero.
                    if (i_out_ready) begin
                        r_state     <= StAccum;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_ovf       <= '0;
                        r_cnt       <= '0;
                        r_out_data  <= '0;
                        r_out_ovf   <= '0;
                    end
                end
                default: begin
                    r_state <= StAccum;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_ovf   = r_out_ovf;
    assign o_out_beats = r_cnt;

endmodule

// File: tb/tb_sat_vec_accum.sv
// Directed bench for sat_vec_accum (WIDTH=16, LANES=4, MAX_BEATS=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sat_vec_accum;

    localparam int W  = 16;
    localparam int L  = 4;
    localparam int MB = 4;
    localparam int CW = $clog2(MB + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [L*W-1:0]  in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [L*W-1:0]  out_data;
    logic [L-1:0]    out_ovf;
    logic [CW-1:0]   out_beats;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0][63:0] beats;
        int               n;
        logic [63:0]      exp_d;
        logic [3:0]       exp_o;
        int               exp_b;
    } vec_t;

    vec_t vecs [5];

    sat_vec_accum #(
        .WIDTH     (W),
        .LANES     (L),
        .MAX_BEATS (MB),
        .GUARD     (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_last   (in_last),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_ovf   (out_ovf),
        .o_out_beats (out_beats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] b0, input logic [63:0] b1,
                                input logic [63:0] b2, input int n, input logic [63:0] d,
                                input logic [3:0] o);
        vec_t v;
        v.beats[0] = b0;
        v.beats[1] = b1;
        v.beats[2] = b2;
        v.beats[3] = '0;
        v.n        = n;
        v.exp_d    = d;
        v.exp_o    = o;
        v.exp_b    = n;
        return v;
    endfunction

    // Feed one vector with in_last on its final beat, check the result, then consume it.
    task automatic run_vec(input vec_t v, input string tag);
        for (int b = 0; b < v.n; b++) begin
            @(negedge clk);
            chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_data  = v.beats[b];
            in_last  = (b == v.n - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " out_data"}, out_data, v.exp_d);
        chk({tag, " out_ovf"}, 64'(out_ovf), 64'(v.exp_o));
        chk({tag, " out_beats"}, 64'(out_beats), 64'(v.exp_b));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " cleared valid"}, 64'(out_valid), 64'd0);
        chk({tag, " cleared ready"}, 64'(in_ready), 64'd1);
        chk({tag, " cleared data"}, out_data, 64'd0);
    endtask

    initial begin
        logic [63:0] held_d;

        vecs[0] = mk(64'h0100_0100_0100_0100, 64'h0200_0200_0200_0200,
                     64'hFF00_FF00_FF00_FF00, 3, 64'h0200_0200_0200_0200, 4'b0000);
`ifdef SAT_VEC_ACCUM_GUARD_EN
        vecs[1] = mk(64'h0000_0000_0000_7000, 64'h0000_0000_0000_2000,
                     64'h0000_0000_0000_A000, 3, 64'h0000_0000_0000_3000, 4'b0000);
        vecs[4] = mk(64'h8000_0000_0000_0001, 64'hFFFF_0000_0000_0002,
                     64'h0001_0000_0000_0003, 3, 64'h8000_0000_0000_0006, 4'b0000);
`else
        vecs[1] = mk(64'h0000_0000_0000_7000, 64'h0000_0000_0000_2000,
                     64'h0000_0000_0000_A000, 3, 64'h0000_0000_0000_1FFF, 4'b0001);
        vecs[4] = mk(64'h8000_0000_0000_0001, 64'hFFFF_0000_0000_0002,
                     64'h0001_0000_0000_0003, 3, 64'h8001_0000_0000_0006, 4'b1000);
`endif
        vecs[2] = mk(64'h0000_0003_7FFF_8000, 64'h0000_FFFF_0001_8000,
                     64'h0, 2, 64'h0000_0002_7FFF_8000, 4'b0011);
        vecs[3] = mk(64'h1234_FFFF_8000_7FFF, 64'h0, 64'h0, 1,
                     64'h1234_FFFF_8000_7FFF, 4'b0000);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data", out_data, 64'd0);
        chk("reset out_ovf", 64'(out_ovf), 64'd0);
        chk("reset out_beats", 64'(out_beats), 64'd0);
        rst = 1'b0;

        // Reset in the middle of a vector drops the partial sums.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 64'h0011_0022_0033_0044;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("midvec beats", 64'(out_beats), 64'd2);
        rst = 1'b1;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        chk("midrst out_data", out_data, 64'd0);
        chk("midrst out_beats", 64'(out_beats), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(64'h0005_0005_0005_0005, 64'h0, 64'h0, 1,
                   64'h0005_0005_0005_0005, 4'b0000), "post-reset");

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held stable, input ignored, until consumed.
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = vecs[0].beats[b];
            in_last  = (b == 2);
        end
        @(negedge clk);
        in_data = 64'h7777_7777_7777_7777;
        in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d data", c), out_data, 64'h0200_0200_0200_0200);
            chk($sformatf("bp%0d ovf", c), 64'(out_ovf), 64'd0);
            chk($sformatf("bp%0d beats", c), 64'(out_beats), 64'd3);
            chk($sformatf("bp%0d in_ready", c), 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release in_ready", 64'(in_ready), 64'd1);
        chk("bp release data", out_data, 64'd0);
        chk("bp release beats", 64'(out_beats), 64'd0);
        run_vec(mk(64'h0001_0002_0003_0004, 64'h0, 64'h0, 1,
                   64'h0001_0002_0003_0004, 4'b0000), "after-bp");

        // Implicit last at MAX_BEATS, then a fifth beat waits for consumption.
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 64'h0001_0001_0001_0001;
            in_last  = 1'b0;
        end
        @(negedge clk);
        in_data = 64'h0100_0100_0100_0100;
        in_last = 1'b1;
        chk("implicit out_valid", 64'(out_valid), 64'd1);
        chk("implicit data", out_data, 64'h0004_0004_0004_0004);
        chk("implicit beats", 64'(out_beats), 64'd4);
        chk("implicit ovf", 64'(out_ovf), 64'd0);
        held_d = out_data;
        repeat (2) @(negedge clk);
        chk("fifth held in_ready", 64'(in_ready), 64'd0);
        chk("fifth held data", out_data, held_d);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("fifth after consume ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("fifth result valid", 64'(out_valid), 64'd1);
        chk("fifth result data", out_data, 64'h0100_0100_0100_0100);
        chk("fifth result beats", 64'(out_beats), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sat_vec_accum.md
# sat_vec_accum

Multi-lane saturating vector accumulator for the LSTM datapath. It sums a stream of signed fixed-point beats, one value per lane, into per-lane accumulators until the last beat of a vector. It then presents the saturated per-lane totals and overflow flags on a valid/ready output. It sits between the gate multipliers and the activation stage, and generalises the combinational two-operand saturating adder to N lanes, multi-cycle accumulation and flow control.

## Interface
- `WIDTH`, 16: lane data width, signed two's complement.
- `LANES`, 4: number of independent accumulation lanes.
- `MAX_BEATS`, 256: maximum beats per vector; beat number `MAX_BEATS` is an implicit last.
- `GUARD`, 4: extra accumulator MSBs. Used only when `SAT_VEC_ACCUM_GUARD_EN` is defined.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: block can accept a beat.
- `in_data` input LANES*WIDTH: lane i is `[i*WIDTH +: WIDTH]`.
- `in_last` input 1: final beat of the vector.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output LANES*WIDTH: saturated lane totals.
- `out_ovf` output LANES: per-lane sticky saturation flag.
- `out_beats` output $clog2(MAX_BEATS+1): number of beats in the vector.

## Operation
- Two-state FSM.
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- A beat is accepted when `in_valid && in_ready`.
- On each accepted beat, every lane computes `acc_i + x_i` at full width plus one bit.
  - On two's-complement overflow, the sum clamps to the accumulator max/min and `ovf_i` is set.
  - `ovf_i` is sticky until the result is consumed.
- The beat counter increments on each accepted beat.
- The FSM moves ACCUM→DONE when the accepted beat has `in_last`=1, or when the counter reaches `MAX_BEATS`.
  - The implicit-last case raises no extra flag.
  - `out_beats` = `MAX_BEATS`.
- DONE→ACCUM happens on `out_valid && out_ready`. In the same edge, accumulators, flags and counter clear to 0.
- `out_data` is driven from registers and is stable while `out_valid`=1 and `out_ready`=0.
- A zero-beat vector is impossible. Results are only produced after at least one accepted beat.
- Reset mid-vector discards the partial sums. No result is emitted.

## Timing
- Reset values:
  - FSM = ACCUM.
  - `in_ready`=1, `out_valid`=0.
  - `out_data`=0, `out_ovf`=0, `out_beats`=0.
  - Accumulators and counter = 0.
- Latency: `out_valid` rises on the clock edge that accepts the last beat, so it is visible in the following cycle.
- After a result is consumed, `in_ready` returns to 1 in the next cycle. There is no same-cycle bypass.
- Throughput is one vector per (beats + 1) cycles when `out_ready`=1.
- `in_ready` depends only on state, not combinationally on `out_ready`.
- `in_data` and `in_last` are ignored when `in_valid`=0 or `in_ready`=0.
- Lanes are fully independent. Saturation in one lane never affects another lane.

## Configuration
- `SAT_VEC_ACCUM_GUARD_EN` defined:
  - Accumulators are WIDTH+GUARD bits.
  - Per-step saturation happens at the WIDTH+GUARD bounds.
  - At the output, each lane clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - `ovf_i` is set if either the per-step clamp or the output clamp occurred.
  - Transient intermediate overflow that returns into range is therefore not flagged.
- Not defined:
  - Accumulators are WIDTH bits.
  - Every step saturates to 0x7FFF/0x8000, matching the existing two-operand adder.
  - `ovf_i` is set on any step clamp.
  - `GUARD` is unused.

## Test plan
All scenarios use WIDTH=16 and LANES=4.

- Reset during accumulation:
  - Stimulus: feed 2 beats without `in_last`, assert `rst`.
  - Response: `out_valid`=0, `in_ready`=1, `out_data`=0 immediately. A subsequent 1-beat vector of 0x0005 yields 0x0005 with `out_beats`=1.
- Basic sum:
  - Stimulus: 3 beats per lane of 0x0100, 0x0200, 0xFF00 (−256), `in_last` on the third.
  - Response: `out_data` lanes = 0x0200, `out_ovf`=0, `out_beats`=3. `out_valid` is high the cycle after the third beat.
- Step saturation, macro undefined:
  - Stimulus: lane0 beats 0x7000, 0x2000, 0xA000.
  - Response: lane0 = 0x1FFF, `out_ovf[0]`=1. Other lanes fed 0 read 0 with ovf=0.
- Same stimulus, macro defined with GUARD=4:
  - Response: lane0 = 0x3000, `out_ovf[0]`=0.
  - Second case: beats 0x8000, 0x8000 give lane0 = 0x8000 with `out_ovf[0]`=1.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles after a result.
  - Response: `out_data`, `out_ovf` and `out_beats` stay stable and `in_ready` stays 0. After `out_ready`=1 for one cycle, `in_ready`=1 on the next cycle and the accumulators read 0.
- Implicit last:
  - Stimulus: MAX_BEATS=4, 4 beats of 0x0001 with `in_last`=0.
  - Response: result 0x0004, `out_beats`=4. A fifth beat offered is not accepted until the result is consumed.
